nco_bank: RTL and testbench
===========================

# nco_bank

Parametrised bank of NCH numerically controlled oscillators, successor to the single-channel `nco`. One shared phase-accumulator adder serves every channel round-robin. Each channel has its own frequency control word, phase offset and enable. Output is a time-multiplexed phase stream with channel tag, valid and wrap strobes, feeding `lutsine` and the DAC mux path.

## Interface
- NCH, 4: number of channels, ≥1.
- ACC_W, 16: accumulator, FCW and offset width.
- PHASE_W, 8: output phase width (top bits of accumulator + offset), ≤ ACC_W.
- CH_W, max(1, clog2(NCH)): channel index width (derived).

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sync  in  1  synchronous phase-align strobe.
- ch_en  in  NCH  per-channel enable (bit k = channel k).
- cfg_we  in  1  config write strobe.
- cfg_sel  in  1  0 = FCW, 1 = phase offset.
- cfg_addr  in  CH_W  target channel.
- cfg_data  in  ACC_W  write data.
- phase_out  out  PHASE_W  phase of the serviced channel.
- ch_out  out  CH_W  channel index of phase_out.
- valid  out  1  phase_out is for an enabled channel.
- wrap  out  1  serviced channel's accumulator overflowed this update.

## Operation
- Slot counter `slot` counts 0..NCH-1 and wraps to 0. Channel `slot` is serviced each cycle, so each channel advances once per NCH cycles.
- Service of channel k, with old = acc[k]:
  - If ch_en[k]=1: acc[k] <= (old + fcw[k]) mod 2^ACC_W. The adder carry-out goes to wrap.
  - If ch_en[k]=0: acc[k] holds and wrap=0.
- Output registers load every cycle:
  - phase_out <= top PHASE_W bits of (old + off[k]) mod 2^ACC_W.
  - ch_out <= k.
  - valid <= ch_en[k].
  - phase_out is still computed for disabled channels; consumers gate on valid.
- Config writes, when cfg_we=1 and cfg_addr < NCH:
  - cfg_sel=0 loads fcw[cfg_addr]; cfg_sel=1 loads off[cfg_addr].
  - Writes with cfg_addr ≥ NCH are ignored.
- Write/service collision: a write to channel k in the cycle k is serviced does not affect that service, which uses the pre-write fcw/off. The new value applies from the next service of k.
- sync=1 has priority over servicing:
  - all acc <= 0 and slot <= 0;
  - valid <= 0, wrap <= 0; phase_out and ch_out hold.
  - fcw/off are unaffected, and a same-cycle cfg write still lands.
- Reset (reset=0, asynchronous): all acc, fcw, off = 0; slot = 0; phase_out = 0, ch_out = 0, valid = 0, wrap = 0. Reset mid-operation discards all state immediately, without a clock edge.
- Reset release: the first rising edge with reset=1 services channel 0.

## Timing
- Latency is 1 cycle, slot → outputs: outputs at edge n+1 describe the channel serviced at edge n.
- Per-channel update period is NCH cycles. Output frequency = fcw·f_clk / (NCH·2^ACC_W).
- After a sync at edge s:
  - edge s+1 services channel 0 with acc=0;
  - phase_out for channel 0 becomes top bits of off[0];
  - channel j follows at s+1+j, all channels phase-aligned to 0.
- ch_out sequence is strictly 0,1,…,NCH-1,0,… except where sync or reset intervenes.
- wrap is a single-cycle pulse coincident with the corresponding phase_out/ch_out.

## Test plan
Defaults: NCH=4, ACC_W=16, PHASE_W=8.
- **Reset:** assert reset=0 mid-run with no clock → phase_out, ch_out, valid, wrap all 0 immediately. After release with ch_en=0 → ch_out cycles 0,1,2,3 and valid stays 0.
- **Basic tone:** write fcw[0]=0x1000, ch_en=4'b0001, pulse sync → channel-0 samples every 4 cycles read 0x00, 0x10, 0x20, …, 0xF0, 0x00. wrap=1 only on the sample where acc steps 0xF000→0x0000; channels 1–3 show valid=0.
- **Offset:** fcw[1]=0, off[1]=0x4000, ch_en=4'b0010 → every ch_out=1 sample reads phase_out=0x40 with valid=1. Then write off[1]=0xC000 → 0xC0 from the next ch1 sample.
- **Collision:** fcw[2]=0x0100, then write fcw[2]=0x0200 in the same cycle slot=2 → that service adds 0x0100. The following ch2 services add 0x0200, giving phase steps of 0x01 then 0x02.
- **Sync priority:** pulse sync together with cfg_we (fcw[3]=0x8000) mid-stream → next cycle valid=0. Then ch_out restarts at 0 with all channels reading off[k] top bits, and fcw[3]=0x8000 is in effect.
- **Bad address:** NCH=3, write cfg_addr=3 → no fcw/off changes; ch_out wraps 0,1,2,0.

Source files
------------

// File: rtl/nco_bank.sv
// Bank of NCH numerically controlled oscillators sharing one phase-accumulator adder.
// Channels are serviced round-robin; the output is a tagged, time-multiplexed phase stream.
module nco_bank #(
   parameter int NCH     = 4,
   parameter int ACC_W   = 16,
   parameter int PHASE_W = 8,
   parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sync,
   input  logic [NCH-1:0]     ch_en,
   input  logic               cfg_we,
   input  logic               cfg_sel,
   input  logic [CH_W-1:0]    cfg_addr,
   input  logic [ACC_W-1:0]   cfg_data,
   output logic [PHASE_W-1:0] phase_out,
   output logic [CH_W-1:0]    ch_out,
   output logic               valid,
   output logic               wrap
);

   logic [ACC_W-1:0] acc [NCH];
   logic [ACC_W-1:0] fcw [NCH];
   logic [ACC_W-1:0] off [NCH];
   logic [CH_W-1:0]  slot;

   logic [ACC_W-1:0] cur_acc;
   logic [ACC_W-1:0] cur_fcw;
   logic [ACC_W-1:0] cur_off;
   logic             cur_en;
   logic [ACC_W:0]   next_sum;
   logic [ACC_W-1:0] offset_sum;

   // Channel select mux feeding the single shared adder; decoding the slot
   // against each channel keeps out-of-range slot values harmless for any NCH.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' and assign every output a
      // default first, so no path leaves a value held and no latch is inferred.
      cur_acc = '0;
      cur_fcw = '0;
      cur_off = '0;
      cur_en  = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (slot == CH_W'(k)) begin
            cur_acc = acc[k];
            cur_fcw = fcw[k];
            cur_off = off[k];
            cur_en  = ch_en[k];
         end
      end
      next_sum   = {1'b0, cur_acc} + {1'b0, cur_fcw};
      offset_sum = cur_acc + cur_off;
   end

   // Config registers read the pre-write value during a same-cycle service,
   // so a collision naturally applies from the next service of that channel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: these per-channel arrays are small register files that must
         // read as zero after reset, so every entry is reset explicitly.
         for (int k = 0; k < NCH; k++) begin
            fcw[k] <= '0;
            off[k] <= '0;
         end
      end else if (cfg_we) begin
         for (int k = 0; k < NCH; k++) begin
            if (cfg_addr == CH_W'(k)) begin
               if (cfg_sel) off[k] <= cfg_data;
               else         fcw[k] <= cfg_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NCH; k++) acc[k] <= '0;
      end else if (sync) begin
         for (int k = 0; k < NCH; k++) acc[k] <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (slot == CH_W'(k) && ch_en[k]) acc[k] <= next_sum[ACC_W-1:0];
         end
      end
   end

   // Slot sequencing and registered outputs; sync restarts at channel 0 and
   // leaves phase_out/ch_out holding their last values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking '<=' so every register
         // samples pre-edge values regardless of statement order.
         slot      <= '0;
         phase_out <= '0;
         ch_out    <= '0;
         valid     <= 1'b0;
         wrap      <= 1'b0;
      end else if (sync) begin
         slot  <= '0;
         valid <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         slot      <= (slot == CH_W'(NCH - 1)) ? '0 : slot + CH_W'(1);
         phase_out <= offset_sum[ACC_W-1 -: PHASE_W];
         ch_out    <= slot;
         valid     <= cur_en;
         wrap      <= cur_en & next_sum[ACC_W];
      end
   end

endmodule

// File: tb/tb_nco_bank.sv
// Self-checking bench for nco_bank: a 4-channel and a 3-channel instance driven in parallel,
// checked against hand-derived vectors and a behavioural per-channel oscillator model.
module tb_nco_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic        sync;
   logic [3:0]  ch_en;
   logic        cfg_we;
   logic        cfg_sel;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_data;

   logic [7:0]  phase4, phase3;
   logic [1:0]  ch4, ch3;
   logic        valid4, valid3, wrap4, wrap3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   nco_bank #(.NCH(4), .ACC_W(16), .PHASE_W(8)) dut4 (
      .clk(clk), .reset(reset), .sync(sync), .ch_en(ch_en),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .phase_out(phase4), .ch_out(ch4), .valid(valid4), .wrap(wrap4)
   );

   nco_bank #(.NCH(3), .ACC_W(16), .PHASE_W(8)) dut3 (
      .clk(clk), .reset(reset), .sync(sync), .ch_en(ch_en[2:0]),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .phase_out(phase3), .ch_out(ch3), .valid(valid3), .wrap(wrap3)
   );

   // Behavioural model: index 0 models the 4-channel bank, index 1 the 3-channel bank.
   int unsigned m_acc [2][4];
   int unsigned m_fcw [2][4];
   int unsigned m_off [2][4];
   int unsigned m_slot[2];
   int unsigned m_ph  [2];
   int unsigned m_ch  [2];
   bit          m_v   [2];
   bit          m_w   [2];

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 4; j++) begin
            m_acc[i][j] = 0;
            m_fcw[i][j] = 0;
            m_off[i][j] = 0;
         end
         m_slot[i] = 0;
         m_ph[i]   = 0;
         m_ch[i]   = 0;
         m_v[i]    = 0;
         m_w[i]    = 0;
      end
   endfunction

   function automatic void model_step(input int i, input int unsigned nch);
      int unsigned k, old, s;
      k = m_slot[i];
      if (sync) begin
         for (int j = 0; j < 4; j++) m_acc[i][j] = 0;
         m_slot[i] = 0;
         m_v[i]    = 0;
         m_w[i]    = 0;
      end else begin
         old      = m_acc[i][k];
         m_ph[i]  = ((old + m_off[i][k]) % 65536) / 256;
         m_ch[i]  = k;
         m_v[i]   = ch_en[k];
         if (ch_en[k]) begin
            s           = old + m_fcw[i][k];
            m_w[i]      = (s >= 65536);
            m_acc[i][k] = s % 65536;
         end else begin
            m_w[i] = 0;
         end
         m_slot[i] = (k + 1) % nch;
      end
      if (cfg_we && cfg_addr < nch) begin
         if (cfg_sel) m_off[i][cfg_addr] = cfg_data;
         else         m_fcw[i][cfg_addr] = cfg_data;
      end
   endfunction

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("m4_phase", phase4, m_ph[0]);
      check("m4_ch",    ch4,    m_ch[0]);
      check("m4_valid", valid4, m_v[0]);
      check("m4_wrap",  wrap4,  m_w[0]);
      check("m3_phase", phase3, m_ph[1]);
      check("m3_ch",    ch3,    m_ch[1]);
      check("m3_valid", valid3, m_v[1]);
      check("m3_wrap",  wrap3,  m_w[1]);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_phase4"}, phase4, 0);
      check({tag, "_ch4"},    ch4,    0);
      check({tag, "_valid4"}, valid4, 0);
      check({tag, "_wrap4"},  wrap4,  0);
      check({tag, "_phase3"}, phase3, 0);
      check({tag, "_ch3"},    ch3,    0);
      check({tag, "_valid3"}, valid3, 0);
      check({tag, "_wrap3"},  wrap3,  0);
   endtask

   // Inputs change only at negedge; one call = one rising edge, sampled at the next negedge.
   task automatic cycle();
      @(posedge clk);
      model_step(0, 4);
      model_step(1, 3);
      @(negedge clk);
      check_model();
   endtask

   task automatic drive(input logic we, input logic sel, input logic [1:0] addr,
                        input logic [15:0] data, input logic [3:0] en, input logic sy);
      cfg_we   = we;
      cfg_sel  = sel;
      cfg_addr = addr;
      cfg_data = data;
      ch_en    = en;
      sync     = sy;
   endtask

   // Mid-run reset with no clock edge in between: outputs must clear at once.
   task automatic async_reset(input string tag);
      #2;
      reset = 1'b0;
      #1;
      check_zero(tag);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      logic        we;
      logic        sel;
      logic [1:0]  addr;
      logic [15:0] data;
      logic [3:0]  en;
      logic        sy;
      logic [7:0]  ph;
      logic [1:0]  ch;
      logic        v;
      logic        w;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic we, input logic sel, input logic [1:0] addr,
                               input logic [15:0] data, input logic [3:0] en, input logic sy,
                               input logic [7:0] ph, input logic [1:0] ch, input logic v,
                               input logic w);
      vec_t t;
      t.we = we; t.sel = sel; t.addr = addr; t.data = data; t.en = en; t.sy = sy;
      t.ph = ph; t.ch = ch; t.v = v; t.w = w;
      vecs.push_back(t);
   endfunction

   initial begin
      // Reset release with everything disabled: plain channel rotation.
      add(0,0,0,16'h0000,4'h0,0, 8'h00,0,0,0);
      add(0,0,0,16'h0000,4'h0,0, 8'h00,1,0,0);
      add(0,0,0,16'h0000,4'h0,0, 8'h00,2,0,0);
      add(0,0,0,16'h0000,4'h0,0, 8'h00,3,0,0);
      // Offset on channel 1, then a new offset taking effect on the next ch1 sample.
      add(1,1,1,16'h4000,4'h2,0, 8'h00,0,0,0);
      add(0,0,0,16'h0000,4'h2,0, 8'h40,1,1,0);
      add(0,0,0,16'h0000,4'h2,0, 8'h00,2,0,0);
      add(1,1,1,16'hC000,4'h2,0, 8'h00,3,0,0);
      add(0,0,0,16'h0000,4'h2,0, 8'h00,0,0,0);
      add(0,0,0,16'h0000,4'h2,0, 8'hC0,1,1,0);
      // Collision: fcw[2] rewritten while channel 2 is being serviced.
      add(1,0,2,16'h0100,4'h4,0, 8'h00,2,1,0);
      add(0,0,0,16'h0000,4'h4,0, 8'h00,3,0,0);
      add(0,0,0,16'h0000,4'h4,0, 8'h00,0,0,0);
      add(0,0,0,16'h0000,4'h4,0, 8'hC0,1,0,0);
      add(1,0,2,16'h0200,4'h4,0, 8'h00,2,1,0);
      add(0,0,0,16'h0000,4'h4,0, 8'h00,3,0,0);
      add(0,0,0,16'h0000,4'h4,0, 8'h00,0,0,0);
      add(0,0,0,16'h0000,4'h4,0, 8'hC0,1,0,0);
      add(0,0,0,16'h0000,4'h4,0, 8'h01,2,1,0);
      add(0,0,0,16'h0000,4'h4,0, 8'h00,3,0,0);
      add(0,0,0,16'h0000,4'h4,0, 8'h00,0,0,0);
      add(0,0,0,16'h0000,4'h4,0, 8'hC0,1,0,0);
      add(0,0,0,16'h0000,4'h4,0, 8'h03,2,1,0);
      // Sync with a same-cycle fcw[3] write: outputs hold, valid drops, write lands.
      add(1,0,3,16'h8000,4'hF,1, 8'h03,2,0,0);
      add(0,0,0,16'h0000,4'hF,0, 8'h00,0,1,0);
      add(0,0,0,16'h0000,4'hF,0, 8'hC0,1,1,0);
      add(0,0,0,16'h0000,4'hF,0, 8'h00,2,1,0);
      add(0,0,0,16'h0000,4'hF,0, 8'h00,3,1,0);
      add(0,0,0,16'h0000,4'hF,0, 8'h00,0,1,0);
      add(0,0,0,16'h0000,4'hF,0, 8'hC0,1,1,0);
      add(0,0,0,16'h0000,4'hF,0, 8'h02,2,1,0);
      add(0,0,0,16'h0000,4'hF,0, 8'h80,3,1,1);
      add(0,0,0,16'h0000,4'hF,0, 8'h00,0,1,0);
      add(0,0,0,16'h0000,4'hF,0, 8'hC0,1,1,0);
      add(0,0,0,16'h0000,4'hF,0, 8'h04,2,1,0);
      add(0,0,0,16'h0000,4'hF,0, 8'h00,3,1,0);

      reset = 1'b0;
      drive(0, 0, 0, 16'h0000, 4'h0, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_zero("por");
      reset = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].data, vecs[i].en, vecs[i].sy);
         cycle();
         check($sformatf("vec%0d_phase", i), phase4, vecs[i].ph);
         check($sformatf("vec%0d_ch",    i), ch4,    vecs[i].ch);
         check($sformatf("vec%0d_valid", i), valid4, vecs[i].v);
         check($sformatf("vec%0d_wrap",  i), wrap4,  vecs[i].w);
      end

      // Basic tone on channel 0: 0x00, 0x10, ..., 0xF0 (with wrap), 0x00.
      drive(1, 0, 0, 16'h1000, 4'h1, 0);
      cycle();
      drive(0, 0, 0, 16'h0000, 4'h1, 1);
      cycle();
      check("tone_sync_valid", valid4, 0);
      sync = 1'b0;
      for (int n = 0; n < 17; n++) begin
         for (int c = 0; c < 4; c++) begin
            cycle();
            check("tone_ch", ch4, c);
            if (c == 0) begin
               check("tone_phase", phase4, (n * 16) % 256);
               check("tone_valid", valid4, 1);
               check("tone_wrap",  wrap4,  (n == 15) ? 1 : 0);
            end else begin
               check("tone_idle_valid", valid4, 0);
            end
         end
      end

      // Mid-run reset, then release with channels disabled; writes to channel 3
      // must be ignored by the 3-channel bank.
      async_reset("mid");
      for (int c = 0; c < 8; c++) begin
         if (c == 0)      drive(1, 0, 3, 16'h1234, 4'h0, 0);
         else if (c == 1) drive(1, 1, 3, 16'h5678, 4'h0, 0);
         else if (c < 4)  drive(0, 0, 0, 16'h0000, 4'h0, 0);
         else             drive(0, 0, 0, 16'h0000, 4'h7, 0);
         cycle();
         check("rel_ch4", ch4, c % 4);
         check("rel_ch3", ch3, c % 3);
         check("rel_phase3", phase3, 0);
         check("rel_wrap3",  wrap3,  0);
         if (c < 4) check("rel_valid4", valid4, 0);
         else       check("rel_valid3", valid3, 1);
      end

      // Randomised traffic against the model, with one asynchronous reset.
      ch_en = 4'($urandom_range(0, 15));
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom_range(0, 15));
         sync     = ($urandom_range(0, 31) == 0);
         cfg_we   = ($urandom_range(0, 2) == 0);
         cfg_sel  = 1'($urandom_range(0, 1));
         cfg_addr = 2'($urandom_range(0, 3));
         cfg_data = 16'($urandom_range(0, 65535));
         cycle();
         if (n == 200) async_reset("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
